// File: rtl/card_reader_rx_if.sv
// Reader-side bus of card_reader_rx: serial card inputs plus the decoded code
// and status outputs consumed by the turnstile controller.
interface card_reader_rx_if;
  logic       card_present;
  logic       bit_valid;
  logic       card_bit;
  logic [3:0] access_code;
  logic       validate_code;
  logic       parity_error;
  logic       frame_error;
  logic       busy;
  logic [1:0] state_out;

  modport master (
    output card_present, bit_valid, card_bit,
    input  access_code, validate_code, parity_error, frame_error, busy, state_out
  );

  modport slave (
    input  card_present, bit_valid, card_bit,
    output access_code, validate_code, parity_error, frame_error, busy, state_out
  );
endinterface

// File: rtl/card_reader_rx.sv
// Contactless card frame receiver: start bit, 4 data bits MSB first, optional
// even parity bit (enabled by defining CARD_PARITY_EN), then a cooldown hold.
module card_reader_rx #(
  parameter logic [7:0] TIMEOUT         = 8'd200,
  parameter logic [7:0] COOLDOWN_CYCLES = 8'd16
) (
  input logic             clk,
  input logic             rst_n,
  card_reader_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    COOLDOWN  = 2'd3
  } state_t;

`ifdef CARD_PARITY_EN
  localparam int SW = 4;
`else
  // Without parity the 4th data bit is merged on the fly, so only 3 are stored.
  localparam int SW = 3;
`endif

  state_t        state_r, state_s;
  logic [1:0]    cnt_r, cnt_s;
  logic [SW-1:0] shift_r, shift_s;
  logic [7:0]    gap_r, gap_s;
  logic [7:0]    cool_r, cool_s;
  logic [3:0]    code_r, code_s;
  logic          valid_r, valid_s;
  logic          perr_r, perr_s;
  logic          ferr_r, ferr_s;

  function automatic logic even_parity_ok(input logic [3:0] data, input logic par);
    return ((^data) ^ par) == 1'b0;
  endfunction

  // Next-state and pulse decode; pulses default low so each lasts one cycle.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shift_s = shift_r;
    gap_s   = gap_r;
    cool_s  = cool_r;
    code_s  = code_r;
    valid_s = 1'b0;
    perr_s  = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.card_present && bus.bit_valid && bus.card_bit) begin
          state_s = RX_DATA;
          cnt_s   = 2'd0;
          shift_s = '0;
          gap_s   = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      RX_DATA: begin
        if (!bus.card_present) begin
          ferr_s  = 1'b1;
          state_s = IDLE;
          gap_s   = 8'd0;
        end else if (bus.bit_valid) begin
          shift_s = {shift_r[SW-2:0], bus.card_bit};
          cnt_s   = cnt_r + 2'd1;
          gap_s   = 8'd0;
          if (cnt_r == 2'd3) begin
`ifdef CARD_PARITY_EN
            state_s = RX_PARITY;
`else
            code_s  = {shift_r, bus.card_bit};
            valid_s = 1'b1;
            cool_s  = 8'd0;
            state_s = COOLDOWN;
`endif
          end else begin
            state_s = RX_DATA;
          end
        end else if (gap_r == TIMEOUT - 8'd1) begin
          ferr_s  = 1'b1;
          state_s = IDLE;
          gap_s   = 8'd0;
        end else begin
          gap_s = gap_r + 8'd1;
        end
      end
      RX_PARITY: begin
`ifdef CARD_PARITY_EN
        if (!bus.card_present) begin
          ferr_s  = 1'b1;
          state_s = IDLE;
          gap_s   = 8'd0;
        end else if (bus.bit_valid) begin
          gap_s = 8'd0;
          if (even_parity_ok(shift_r, bus.card_bit)) begin
            code_s  = shift_r;
            valid_s = 1'b1;
            cool_s  = 8'd0;
            state_s = COOLDOWN;
          end else begin
            perr_s  = 1'b1;
            state_s = IDLE;
          end
        end else if (gap_r == TIMEOUT - 8'd1) begin
          ferr_s  = 1'b1;
          state_s = IDLE;
          gap_s   = 8'd0;
        end else begin
          gap_s = gap_r + 8'd1;
        end
`else
        state_s = IDLE;
`endif
      end
      COOLDOWN: begin
        if (cool_r == COOLDOWN_CYCLES - 8'd1) begin
          state_s = IDLE;
          cool_s  = 8'd0;
        end else begin
          cool_s = cool_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      shift_r <= '0;
      gap_r   <= 8'd0;
      cool_r  <= 8'd0;
      code_r  <= 4'd0;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shift_r <= shift_s;
      gap_r   <= gap_s;
      cool_r  <= cool_s;
      code_r  <= code_s;
      valid_r <= valid_s;
      perr_r  <= perr_s;
      ferr_r  <= ferr_s;
    end
  end

  assign bus.access_code   = code_r;
  assign bus.validate_code = valid_r;
`ifdef CARD_PARITY_EN
  assign bus.parity_error  = perr_r;
`else
  assign bus.parity_error  = 1'b0;
`endif
  assign bus.frame_error   = ferr_r;
  assign bus.busy          = (state_r != IDLE);
  assign bus.state_out     = state_r;

endmodule

// File: tb/tb_card_reader_rx.sv
// Directed bench for card_reader_rx; adapts frame length to CARD_PARITY_EN.
module tb_card_reader_rx;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   vcount = 0;
  int   pcount = 0;
  int   multi = 0;
  int   v0;
  logic ok;

  always #5 clk = ~clk;

  card_reader_rx_if bus ();

  card_reader_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Pulse bookkeeping: each one-cycle pulse is seen at exactly one rising edge.
  always @(posedge clk) begin
    if (bus.validate_code === 1'b1) vcount++;
    if (bus.parity_error === 1'b1) pcount++;
    if ((32'(bus.validate_code) + 32'(bus.parity_error) + 32'(bus.frame_error)) > 32'd1) multi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1;
    bus.card_bit  = b;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    bus.card_bit  = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] code, input logic flip);
    send_bit(1'b1);
    for (int i = 3; i >= 0; i--) send_bit(code[i]);
`ifdef CARD_PARITY_EN
    send_bit((^code) ^ flip);
`endif
  endtask

  initial begin
    bus.card_present = 1'b0;
    bus.bit_valid    = 1'b0;
    bus.card_bit     = 1'b0;
    rst_n            = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_code",  32'(bus.access_code),   32'd0);
    chk("rst_valid", 32'(bus.validate_code), 32'd0);
    chk("rst_perr",  32'(bus.parity_error),  32'd0);
    chk("rst_ferr",  32'(bus.frame_error),   32'd0);
    chk("rst_busy",  32'(bus.busy),          32'd0);
    chk("rst_state", 32'(bus.state_out),     32'd0);
    rst_n = 1'b1;
    bus.card_present = 1'b1;
    @(negedge clk);

    // Good frame, code 7, then a 16-cycle cooldown.
    send_frame(4'd7, 1'b0);
    chk("good_valid", 32'(bus.validate_code), 32'd1);
    chk("good_code",  32'(bus.access_code),   32'd7);
    chk("good_state", 32'(bus.state_out),     32'd3);
    @(negedge clk);
    chk("good_pulse_end", 32'(bus.validate_code), 32'd0);
    ok = 1'b1;
    for (int i = 2; i <= 15; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.access_code !== 4'd7) ok = 1'b0;
    end
    chk("cool_busy_hold", 32'(ok), 32'd1);
    @(negedge clk);
    chk("cool_end_state", 32'(bus.state_out), 32'd0);
    chk("cool_end_busy",  32'(bus.busy),      32'd0);

`ifdef CARD_PARITY_EN
    send_frame(4'd5, 1'b1);
    chk("perr_pulse", 32'(bus.parity_error),  32'd1);
    chk("perr_code",  32'(bus.access_code),   32'd7);
    chk("perr_valid", 32'(bus.validate_code), 32'd0);
    chk("perr_state", 32'(bus.state_out),     32'd0);
    @(negedge clk);
    chk("perr_pulse_end", 32'(bus.parity_error), 32'd0);
`else
    send_frame(4'b1010, 1'b0);
    chk("nopar_valid", 32'(bus.validate_code), 32'd1);
    chk("nopar_code",  32'(bus.access_code),   32'd10);
    repeat (16) @(negedge clk);
    chk("nopar_idle", 32'(bus.state_out), 32'd0);
`endif

    // Timeout: start + 2 data bits, then silence.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ok = 1'b1;
    repeat (199) begin
      @(negedge clk);
      if (bus.frame_error !== 1'b0 || bus.state_out !== 2'd1) ok = 1'b0;
    end
    chk("to_no_early", 32'(ok), 32'd1);
    @(negedge clk);
    chk("to_ferr",  32'(bus.frame_error), 32'd1);
    chk("to_state", 32'(bus.state_out),   32'd0);
    @(negedge clk);
    chk("to_ferr_end", 32'(bus.frame_error), 32'd0);
    send_frame(4'd4, 1'b0);
    chk("after_to_valid", 32'(bus.validate_code), 32'd1);
    chk("after_to_code",  32'(bus.access_code),   32'd4);
    repeat (16) @(negedge clk);

    // Card removed after 3 data bits.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.card_present = 1'b0;
    @(negedge clk);
    chk("rm_ferr",  32'(bus.frame_error), 32'd1);
    chk("rm_state", 32'(bus.state_out),   32'd0);
    bus.card_present = 1'b1;
    @(negedge clk);
    chk("rm_ferr_end", 32'(bus.frame_error), 32'd0);

    // A full frame during cooldown is ignored.
    send_frame(4'd12, 1'b0);
    chk("cd_code", 32'(bus.access_code), 32'd12);
    @(negedge clk);
    v0 = vcount;
    send_frame(4'd3, 1'b0);
    @(negedge clk);
    chk("cd_no_pulse", 32'(vcount - v0),     32'd0);
    chk("cd_code_hold", 32'(bus.access_code), 32'd12);
    chk("cd_state",    32'(bus.state_out),   32'd3);
    repeat (10) @(negedge clk);
    chk("cd_idle", 32'(bus.state_out), 32'd0);

    // Reset mid-frame.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_code",  32'(bus.access_code), 32'd0);
    chk("mrst_busy",  32'(bus.busy),        32'd0);
    chk("mrst_state", 32'(bus.state_out),   32'd0);
    @(negedge clk);
    chk("mrst_ferr", 32'(bus.frame_error), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(4'd11, 1'b0);
    chk("mrst_valid", 32'(bus.validate_code), 32'd1);
    chk("mrst_new",   32'(bus.access_code),   32'd11);
    repeat (16) @(negedge clk);

    // A bit landing exactly on the timeout cycle is accepted.
    send_bit(1'b1);
    repeat (199) @(negedge clk);
    send_bit(1'b1);
    chk("edge_ferr",  32'(bus.frame_error), 32'd0);
    chk("edge_state", 32'(bus.state_out),   32'd1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
`ifdef CARD_PARITY_EN
    send_bit(1'b0);
`endif
    chk("edge_valid", 32'(bus.validate_code), 32'd1);
    chk("edge_code",  32'(bus.access_code),   32'd9);
    repeat (16) @(negedge clk);
    chk("edge_idle", 32'(bus.state_out), 32'd0);

`ifdef CARD_PARITY_EN
    chk("perr_count", 32'(pcount), 32'd1);
`else
    chk("perr_never", 32'(pcount), 32'd0);
`endif
    chk("pulse_excl", 32'(multi), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
